// File: rtl/image_stream_feeder_pkg.sv
// Shared definitions for the image pipeline: feeder FSM states and pixel geometry.
// Used by image_stream_feeder and the brightness processor.
package image_stream_feeder_pkg;

  localparam int COLOR_SIZE = 8;
  localparam int PIXEL_SIZE = 24;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/image_stream_feeder_if.sv
// Memory read port and downstream word stream of the image feeder.
// The master is the feeder; the slave is the memory/processor side.
interface image_stream_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  hold;
  logic                  vld;
  logic                  last_data;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output mem_rd_en, mem_addr, vld, last_data, data_out,
    input  mem_rd_data, hold
  );

  modport slave (
    input  mem_rd_en, mem_addr, vld, last_data, data_out,
    output mem_rd_data, hold
  );

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO between the memory read return and the registered stream output.
// When empty, the word being pushed is visible at dout and may be popped in the same cycle.
module stream_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  wr;
  logic                  rd;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign dout  = empty ? din : mem[rd_ptr];
  assign wr    = push && !(pop && empty);
  assign rd    = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  end

  // NOTE: storage has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/image_stream_feeder.sv
// Streams word_cnt consecutive memory words to the processor with at most two words
// buffered or in flight, then waits for proc_done and pulses finished.
module image_stream_feeder
  import image_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_cnt,
  input  logic                  proc_done,
  output logic                  busy,
  output logic                  finished,
  image_stream_feeder_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] popped_q;
  logic                  inflight_q;
  logic                  vld_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  finished_q;

  logic                  issue;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Read data arrives the cycle after its strobe, so the in-flight flag is the push.
  stream_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (bus.mem_rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    issue     = 1'b0;
    occupancy = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
    pending   = 3'd0;
    case (state_q)
      IDLE: begin
        if (start && word_cnt != '0) state_d = STREAM;
      end
      STREAM: begin
        pop     = !bus.hold && (!fifo_empty || inflight_q);
        pending = occupancy + {2'b00, inflight_q} - {2'b00, pop};
        issue   = (issued_q != cnt_q) && (pending < 3'd2);
        if (last_q) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (proc_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      finished_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      vld_q      <= pop;
      data_q     <= pop ? fifo_dout : '0;
      last_q     <= pop && (popped_q == cnt_q - ADDR_ONE);
      finished_q <= (state_q == IDLE && start && word_cnt == '0) ||
                    (state_q == WAIT_DONE && proc_done);
      if (state_q == IDLE && start) begin
        addr_q   <= base_addr;
        cnt_q    <= word_cnt;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_ONE;
          issued_q <= issued_q + ADDR_ONE;
        end
        if (pop) popped_q <= popped_q + ADDR_ONE;
      end
    end
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = issue ? addr_q : '0;
  assign bus.vld       = vld_q;
  assign bus.last_data = last_q;
  assign bus.data_out  = data_q;
  assign busy          = (state_q != IDLE);
  assign finished      = finished_q;

endmodule

// File: tb/tb_image_stream_feeder.sv
// Self-checking bench for image_stream_feeder: directed job table, reset/start corner
// sequences and randomized jobs checked against a word-list/occupancy reference model.
module tb_image_stream_feeder;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_cnt;
  logic          proc_done;
  logic          busy;
  logic          finished;

  image_stream_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  image_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .proc_done (proc_done),
    .busy      (busy),
    .finished  (finished),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, garbage on the bus when not reading.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : DW'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle log of one job, cycle 0 = the cycle start is driven.
  logic          lg_vld  [MAXC];
  logic          lg_last [MAXC];
  logic [DW-1:0] lg_data [MAXC];
  logic          lg_rd   [MAXC];
  logic [AW-1:0] lg_addr [MAXC];
  logic          lg_fin  [MAXC];
  logic          lg_busy [MAXC];
  logic          lg_hold [MAXC];
  int ncyc, r_first, r_last, r_fin, r_pd;

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n,
                         input int hold_lo, input int hold_hi, input bit rnd_hold,
                         input int done_cycle, input bit inject);
    int  last_cyc = -1;
    int  after    = 0;
    bit  fin_seen = 1'b0;
    int  budget   = 4 * int'(n) + 60;
    r_first = -1; r_last = -1; r_fin = -1; r_pd = -1; ncyc = 0;
    for (int c = 0; c < budget; c++) begin
      start     = (c == 0) || (inject && c == 5);
      base_addr = (c == 0) ? b : 16'hABCD;
      word_cnt  = (c == 0) ? n : 16'd3;
      bus.hold  = rnd_hold ? ($urandom_range(0, 2) == 0) : (c >= hold_lo && c <= hold_hi);
      proc_done = !fin_seen && ((done_cycle >= 0) ? (c >= done_cycle)
                                                  : (last_cyc >= 0 && c >= last_cyc + 2));
      if (proc_done && r_pd < 0) r_pd = c;
      @(negedge clk);
      lg_vld[c]  = bus.vld;      lg_last[c] = bus.last_data; lg_data[c] = bus.data_out;
      lg_rd[c]   = bus.mem_rd_en; lg_addr[c] = bus.mem_addr;
      lg_fin[c]  = finished;     lg_busy[c] = busy;          lg_hold[c] = bus.hold;
      ncyc = c + 1;
      if (bus.vld && r_first < 0) r_first = c;
      if (bus.vld) r_last = c;
      if (bus.vld && bus.last_data) last_cyc = c;
      if (finished && !fin_seen) begin
        fin_seen = 1'b1;
        r_fin    = c;
      end
      @(posedge clk); #1;
      if (fin_seen) begin
        after++;
        if (after >= 3) break;
      end
    end
    start = 1'b0; bus.hold = 1'b0; proc_done = 1'b0;
  endtask

  // Reference: word k must be mem[base+k mod 2^16], reads go out in address order,
  // reads issued minus words popped never exceeds 2, hold blanks the next cycle's vld.
  task automatic check_job(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] n,
                           input bit timing, input int exp_first, input int exp_last,
                           input int exp_fin);
    int k = 0, j = 0, last_bad = 0, addr_bad = 0, idle_bad = 0, hold_bad = 0;
    int over = 0, busy_bad = 0, fins = 0, iss = 0, vc = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (lg_vld[c]) begin
        if (k < int'(n))
          check($sformatf("%s_word%0d", tag, k), 64'(lg_data[c]), 64'(mem[b + AW'(k)]));
        if (lg_last[c] != (k == int'(n) - 1)) last_bad++;
        k++;
      end else if (lg_last[c] || lg_data[c] != '0) begin
        idle_bad++;
      end
      if (lg_rd[c]) begin
        if (lg_addr[c] != b + AW'(j)) addr_bad++;
        j++;
      end
      if (lg_hold[c] && c + 1 < ncyc && lg_vld[c+1]) hold_bad++;
      if (lg_fin[c]) fins++;
      if (c >= 1 && r_fin >= 0 && c < r_fin && lg_busy[c] != (n != '0)) busy_bad++;
    end
    if (lg_busy[0]) busy_bad++;
    if (r_fin >= 0 && lg_busy[r_fin]) busy_bad++;
    vc = int'(lg_vld[0]);
    for (int c = 0; c + 1 < ncyc; c++) begin
      iss += int'(lg_rd[c]);
      vc  += int'(lg_vld[c+1]);
      if (iss - vc > 2) over++;
    end
    check({tag, "_word_count"}, 64'(k), 64'(n));
    check({tag, "_read_count"}, 64'(j), 64'(n));
    check({tag, "_read_addr"}, 64'(addr_bad), 64'd0);
    check({tag, "_last_flag"}, 64'(last_bad), 64'd0);
    check({tag, "_idle_zero"}, 64'(idle_bad), 64'd0);
    check({tag, "_hold_blank"}, 64'(hold_bad), 64'd0);
    check({tag, "_outstanding"}, 64'(over), 64'd0);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_fin_cycle"}, 64'(r_fin), 64'(exp_fin));
    check({tag, "_fin_pulses"}, 64'(fins), 64'd1);
    if (timing) begin
      check({tag, "_first_vld"}, 64'(r_first), 64'(exp_first));
      check({tag, "_last_vld"}, 64'(r_last), 64'(exp_last));
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    int hold_lo, hold_hi, done_cycle;
    int exp_first, exp_last, exp_fin;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic          act;
    logic [AW-1:0] rb, rn;
    bit            inj;

    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'hA0 + i;

    //        base      cnt  hold_lo hold_hi done first last fin
    vecs[0] = '{16'h0010, 4, -1, -1,  8,  3,  6,  9};
    // hold is sampled into the registered vld, so driving it in 3-6 blanks vld in 4-7
    vecs[1] = '{16'h0100, 8,  3,  6, 16,  3, 14, 17};
    vecs[2] = '{16'h0020, 0, -1, -1, -1, -1, -1,  1};
    vecs[3] = '{16'h0055, 1, -1, -1,  5,  3,  3,  6};
    vecs[4] = '{16'hFFFE, 4, -1, -1,  8,  3,  6,  9};
    vecs[5] = '{16'h7FFE, 3,  7,  9,  7,  3,  5,  8};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    proc_done = 1'b0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus.vld, bus.last_data, bus.data_out, bus.mem_rd_en,
                                bus.mem_addr, busy, finished}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].base, vecs[v].cnt, vecs[v].hold_lo, vecs[v].hold_hi, 1'b0,
              vecs[v].done_cycle, 1'b0);
      check_job($sformatf("vec%0d", v), vecs[v].base, vecs[v].cnt, 1'b1,
                vecs[v].exp_first, vecs[v].exp_last, vecs[v].exp_fin);
    end

    // A second start with a different base/count in cycle 5 must be ignored.
    run_job(16'h0300, 16'd8, -1, -1, 1'b0, 20, 1'b1);
    check_job("start_ignored", 16'h0300, 16'd8, 1'b1, 3, 10, 21);

    // Reset in cycle 4 of an 8-word job aborts it silently.
    start = 1'b1; base_addr = 16'h0200; word_cnt = 16'd8;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_c4", 64'(busy), 64'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs_c5", 64'({bus.vld, bus.last_data, bus.data_out, bus.mem_rd_en,
                                    bus.mem_addr, busy, finished}), 64'd0);
    act = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      @(negedge clk);
      act = act | bus.vld | bus.mem_rd_en | finished | busy;
    end
    check("midrst_quiet", 64'(act), 64'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 24; r++) begin
      rb  = AW'($urandom);
      rn  = AW'($urandom_range(0, 12));
      inj = (rn >= 16'd8) && ($urandom_range(0, 1) == 1);
      run_job(rb, rn, 0, 0, 1'b1, -1, inj);
      check_job($sformatf("rnd%0d", r), rb, rn, 1'b0, 0, 0,
                (rn == '0) ? 1 : ((r_pd < 0) ? -99 : r_pd + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
